// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encodings and control-vector layout for the Mini SRC control unit.
package cpu_ctrl_pkg;

    localparam int unsigned OPCODE_WIDTH    = 5;
    localparam int unsigned CLR_STATE_WIDTH = 6;

    localparam logic [OPCODE_WIDTH-1:0] ADD_OP = 5'b00011;

    // Mini SRC opcode map, ir[31:27]
    localparam logic [OPCODE_WIDTH-1:0]
        OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7,
        OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10, OP_ROL  = 5'd11,
        OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15,
        OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19,
        OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23,
        OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

    typedef enum logic [CLR_STATE_WIDTH-1:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_HALT,
        S_ALU_T3, S_ALU_T4, S_ALU_T5,
        S_IMM_T3, S_IMM_T4, S_IMM_T5,
        S_LDST_T3, S_LDST_T4, S_LDI_T5,
        S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T5, S_ST_T6, S_ST_T7,
        S_MUL_T3, S_MUL_T4, S_MUL_T5, S_MUL_T6,
        S_NEG_T3, S_NEG_T4,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_JR_T3, S_JAL_T3, S_JAL_T4,
        S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3
    } state_e;

    typedef struct packed {
        logic                    run;
        logic                    pc_out;
        logic                    zhigh_out;
        logic                    zlow_out;
        logic                    hi_out;
        logic                    lo_out;
        logic                    in_port_out;
        logic                    c_out;
        logic                    mdr_out;
        logic                    mdr_enable;
        logic                    mar_enable;
        logic                    z_enable;
        logic                    y_enable;
        logic                    pc_enable;
        logic                    lo_enable;
        logic                    hi_enable;
        logic                    ir_enable;
        logic                    con_enable;
        logic                    inc_pc;
        logic                    read;
        logic                    ram_write_enable;
        logic                    out_port_enable;
        logic                    gra;
        logic                    grb;
        logic                    grc;
        logic                    r_in;
        logic                    r_out;
        logic                    ba_out;
        logic [OPCODE_WIDTH-1:0] opcode;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: maps the current micro-step (plus IR opcode and CON FF) to the datapath control vector.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e                  state_i,
    input  logic [OPCODE_WIDTH-1:0] ir_op_i,
    input  logic                    con_ff_i,
    output ctrl_t                   ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.run    = 1'b1;
        ctrl_o.opcode = ir_op_i;
        case (state_i)
            S_RESET, S_HALT: begin
                ctrl_o.run    = 1'b0;
                ctrl_o.opcode = '0;
            end
            S_FETCH0: begin
                ctrl_o.pc_out     = 1'b1;
                ctrl_o.mar_enable = 1'b1;
                ctrl_o.inc_pc     = 1'b1;
            end
            S_FETCH1, S_LD_T6: begin
                ctrl_o.read       = 1'b1;
                ctrl_o.mdr_enable = 1'b1;
            end
            S_FETCH2: begin
                ctrl_o.mdr_out   = 1'b1;
                ctrl_o.ir_enable = 1'b1;
            end
            S_ALU_T3, S_IMM_T3: begin
                ctrl_o.grb      = 1'b1;
                ctrl_o.r_out    = 1'b1;
                ctrl_o.y_enable = 1'b1;
            end
            S_ALU_T4: begin
                ctrl_o.grc      = 1'b1;
                ctrl_o.r_out    = 1'b1;
                ctrl_o.z_enable = 1'b1;
            end
            S_IMM_T4: begin
                ctrl_o.c_out    = 1'b1;
                ctrl_o.z_enable = 1'b1;
            end
            S_ALU_T5, S_IMM_T5, S_LDI_T5, S_NEG_T4: begin
                ctrl_o.zlow_out = 1'b1;
                ctrl_o.gra      = 1'b1;
                ctrl_o.r_in     = 1'b1;
            end
            S_LDST_T3: begin
                ctrl_o.grb      = 1'b1;
                ctrl_o.ba_out   = 1'b1;
                ctrl_o.y_enable = 1'b1;
            end
            // Effective address and branch target both use the ALU adder
            S_LDST_T4, S_BR_T5: begin
                ctrl_o.c_out    = 1'b1;
                ctrl_o.opcode   = ADD_OP;
                ctrl_o.z_enable = 1'b1;
            end
            S_LD_T5, S_ST_T5: begin
                ctrl_o.zlow_out   = 1'b1;
                ctrl_o.mar_enable = 1'b1;
            end
            S_LD_T7: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.gra     = 1'b1;
                ctrl_o.r_in    = 1'b1;
            end
            S_ST_T6: begin
                ctrl_o.gra        = 1'b1;
                ctrl_o.r_out      = 1'b1;
                ctrl_o.mdr_enable = 1'b1;
            end
            S_ST_T7: ctrl_o.ram_write_enable = 1'b1;
            S_MUL_T3: begin
                ctrl_o.gra      = 1'b1;
                ctrl_o.r_out    = 1'b1;
                ctrl_o.y_enable = 1'b1;
            end
            S_MUL_T4, S_NEG_T3: begin
                ctrl_o.grb      = 1'b1;
                ctrl_o.r_out    = 1'b1;
                ctrl_o.z_enable = 1'b1;
            end
            S_MUL_T5: begin
                ctrl_o.zlow_out  = 1'b1;
                ctrl_o.lo_enable = 1'b1;
            end
            S_MUL_T6: begin
                ctrl_o.zhigh_out = 1'b1;
                ctrl_o.hi_enable = 1'b1;
            end
            S_BR_T3: begin
                ctrl_o.gra        = 1'b1;
                ctrl_o.r_out      = 1'b1;
                ctrl_o.con_enable = 1'b1;
            end
            S_BR_T4: begin
                ctrl_o.pc_out   = 1'b1;
                ctrl_o.y_enable = 1'b1;
            end
            S_BR_T6: begin
                ctrl_o.zlow_out  = 1'b1;
                ctrl_o.pc_enable = con_ff_i;
            end
            S_JR_T3, S_JAL_T4: begin
                ctrl_o.gra       = 1'b1;
                ctrl_o.r_out     = 1'b1;
                ctrl_o.pc_enable = 1'b1;
            end
            S_JAL_T3: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.grb    = 1'b1;
                ctrl_o.r_in   = 1'b1;
            end
            S_IN_T3: begin
                ctrl_o.in_port_out = 1'b1;
                ctrl_o.gra         = 1'b1;
                ctrl_o.r_in        = 1'b1;
            end
            S_OUT_T3: begin
                ctrl_o.gra             = 1'b1;
                ctrl_o.r_out           = 1'b1;
                ctrl_o.out_port_enable = 1'b1;
            end
            S_MFHI_T3: begin
                ctrl_o.hi_out = 1'b1;
                ctrl_o.gra    = 1'b1;
                ctrl_o.r_in   = 1'b1;
            end
            S_MFLO_T3: begin
                ctrl_o.lo_out = 1'b1;
                ctrl_o.gra    = 1'b1;
                ctrl_o.r_in   = 1'b1;
            end
            default: begin
                ctrl_o.run    = 1'b0;
                ctrl_o.opcode = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini SRC control sequencer: state register and next-state logic; outputs decoded in ctrl_output_decode.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    clr,
    input  logic [31:0]             ir,
    input  logic                    con_ff,
    input  logic                    stop,
    output logic                    run,
    output logic                    PC_out,
    output logic                    ZHigh_out,
    output logic                    ZLow_out,
    output logic                    HI_out,
    output logic                    LO_out,
    output logic                    In_port_out,
    output logic                    C_out,
    output logic                    MDR_out,
    output logic                    MDR_enable,
    output logic                    MAR_enable,
    output logic                    Z_enable,
    output logic                    Y_enable,
    output logic                    PC_enable,
    output logic                    LO_enable,
    output logic                    HI_enable,
    output logic                    IR_enable,
    output logic                    CON_enable,
    output logic                    IncPC,
    output logic                    Read,
    output logic                    RAM_write_enable,
    output logic                    out_port_enable,
    output logic                    Gra,
    output logic                    Grb,
    output logic                    Grc,
    output logic                    R_in,
    output logic                    R_out,
    output logic                    BA_out,
    output logic [OPCODE_WIDTH-1:0] opcode
);

    state_e                  state_q, state_d;
    logic                    to_fetch;
    logic [OPCODE_WIDTH-1:0] ir_op;
    logic                    unused_ir_bits;
    ctrl_t                   ctrl;

    assign ir_op          = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        to_fetch = 1'b0;
        case (state_q)
            S_RESET:   to_fetch = 1'b1;
            S_FETCH0:  state_d = S_FETCH1;
            S_FETCH1:  state_d = S_FETCH2;
            S_FETCH2: begin
                case (ir_op)
                    OP_LD, OP_LDI, OP_ST:                 state_d = S_LDST_T3;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
                    OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      state_d = S_ALU_T3;
                    OP_ADDI, OP_ANDI, OP_ORI:             state_d = S_IMM_T3;
                    OP_MUL, OP_DIV:                       state_d = S_MUL_T3;
                    OP_NEG, OP_NOT:                       state_d = S_NEG_T3;
                    OP_BR:                                state_d = S_BR_T3;
                    OP_JR:                                state_d = S_JR_T3;
                    OP_JAL:                               state_d = S_JAL_T3;
                    OP_IN:                                state_d = S_IN_T3;
                    OP_OUT:                               state_d = S_OUT_T3;
                    OP_MFHI:                              state_d = S_MFHI_T3;
                    OP_MFLO:                              state_d = S_MFLO_T3;
                    OP_HALT:                              state_d = S_HALT;
                    default:                              to_fetch = 1'b1;
                endcase
            end
            S_ALU_T3:  state_d = S_ALU_T4;
            S_ALU_T4:  state_d = S_ALU_T5;
            S_IMM_T3:  state_d = S_IMM_T4;
            S_IMM_T4:  state_d = S_IMM_T5;
            S_LDST_T3: state_d = S_LDST_T4;
            S_LDST_T4: begin
                if (ir_op == OP_LDI)     state_d = S_LDI_T5;
                else if (ir_op == OP_LD) state_d = S_LD_T5;
                else                     state_d = S_ST_T5;
            end
            S_LD_T5:   state_d = S_LD_T6;
            S_LD_T6:   state_d = S_LD_T7;
            S_ST_T5:   state_d = S_ST_T6;
            S_ST_T6:   state_d = S_ST_T7;
            S_MUL_T3:  state_d = S_MUL_T4;
            S_MUL_T4:  state_d = S_MUL_T5;
            S_MUL_T5:  state_d = S_MUL_T6;
            S_NEG_T3:  state_d = S_NEG_T4;
            S_BR_T3:   state_d = S_BR_T4;
            S_BR_T4:   state_d = S_BR_T5;
            S_BR_T5:   state_d = S_BR_T6;
            S_JAL_T3:  state_d = S_JAL_T4;
            S_HALT:    state_d = S_HALT;
            S_ALU_T5, S_IMM_T5, S_LDI_T5, S_LD_T7, S_ST_T7, S_MUL_T6,
            S_NEG_T4, S_BR_T6, S_JR_T3, S_JAL_T4, S_IN_T3, S_OUT_T3,
            S_MFHI_T3, S_MFLO_T3: to_fetch = 1'b1;
            default:   state_d = S_RESET;
        endcase
        // stop only takes effect at an instruction boundary
        if (to_fetch) state_d = stop ? S_HALT : S_FETCH0;
    end

    ctrl_output_decode u_decode (
        .state_i  (state_q),
        .ir_op_i  (ir_op),
        .con_ff_i (con_ff),
        .ctrl_o   (ctrl)
    );

    assign run              = ctrl.run;
    assign PC_out           = ctrl.pc_out;
    assign ZHigh_out        = ctrl.zhigh_out;
    assign ZLow_out         = ctrl.zlow_out;
    assign HI_out           = ctrl.hi_out;
    assign LO_out           = ctrl.lo_out;
    assign In_port_out      = ctrl.in_port_out;
    assign C_out            = ctrl.c_out;
    assign MDR_out          = ctrl.mdr_out;
    assign MDR_enable       = ctrl.mdr_enable;
    assign MAR_enable       = ctrl.mar_enable;
    assign Z_enable         = ctrl.z_enable;
    assign Y_enable         = ctrl.y_enable;
    assign PC_enable        = ctrl.pc_enable;
    assign LO_enable        = ctrl.lo_enable;
    assign HI_enable        = ctrl.hi_enable;
    assign IR_enable        = ctrl.ir_enable;
    assign CON_enable       = ctrl.con_enable;
    assign IncPC            = ctrl.inc_pc;
    assign Read             = ctrl.read;
    assign RAM_write_enable = ctrl.ram_write_enable;
    assign out_port_enable  = ctrl.out_port_enable;
    assign Gra              = ctrl.gra;
    assign Grb              = ctrl.grb;
    assign Grc              = ctrl.grc;
    assign R_in             = ctrl.r_in;
    assign R_out            = ctrl.r_out;
    assign BA_out           = ctrl.ba_out;
    assign opcode           = ctrl.opcode;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle control vectors are queued, then popped against the DUT.
module tb_control_unit;

    typedef logic [32:0] vec_t;

    localparam vec_t M_RUN   = vec_t'(1) << 32;
    localparam vec_t M_PCO   = vec_t'(1) << 31;
    localparam vec_t M_ZHO   = vec_t'(1) << 30;
    localparam vec_t M_ZLO   = vec_t'(1) << 29;
    localparam vec_t M_HIO   = vec_t'(1) << 28;
    localparam vec_t M_LOO   = vec_t'(1) << 27;
    localparam vec_t M_INO   = vec_t'(1) << 26;
    localparam vec_t M_CO    = vec_t'(1) << 25;
    localparam vec_t M_MDRO  = vec_t'(1) << 24;
    localparam vec_t M_MDRE  = vec_t'(1) << 23;
    localparam vec_t M_MARE  = vec_t'(1) << 22;
    localparam vec_t M_ZE    = vec_t'(1) << 21;
    localparam vec_t M_YE    = vec_t'(1) << 20;
    localparam vec_t M_PCE   = vec_t'(1) << 19;
    localparam vec_t M_LOE   = vec_t'(1) << 18;
    localparam vec_t M_HIE   = vec_t'(1) << 17;
    localparam vec_t M_IRE   = vec_t'(1) << 16;
    localparam vec_t M_CONE  = vec_t'(1) << 15;
    localparam vec_t M_INC   = vec_t'(1) << 14;
    localparam vec_t M_RD    = vec_t'(1) << 13;
    localparam vec_t M_WR    = vec_t'(1) << 12;
    localparam vec_t M_OUTE  = vec_t'(1) << 11;
    localparam vec_t M_GRA   = vec_t'(1) << 10;
    localparam vec_t M_GRB   = vec_t'(1) << 9;
    localparam vec_t M_GRC   = vec_t'(1) << 8;
    localparam vec_t M_RIN   = vec_t'(1) << 7;
    localparam vec_t M_ROUT  = vec_t'(1) << 6;
    localparam vec_t M_BAO   = vec_t'(1) << 5;
    localparam vec_t V_ADDOP = vec_t'(5'b00011);
    localparam vec_t V_IDLE  = '0;

    logic clk, clr, con_ff, stop;
    logic [31:0] ir;
    logic run, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out;
    logic MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable, IR_enable;
    logic CON_enable, IncPC, Read, RAM_write_enable, out_port_enable;
    logic Gra, Grb, Grc, R_in, R_out, BA_out;
    logic [4:0] opcode;

    vec_t obs;
    vec_t exp_v;
    vec_t exp_q[$];
    int   vectors;
    int   miscompares;

    assign obs = {run, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out, MDR_out,
                  MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable,
                  IR_enable, CON_enable, IncPC, Read, RAM_write_enable, out_port_enable,
                  Gra, Grb, Grc, R_in, R_out, BA_out, opcode};

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
        .LO_out(LO_out), .In_port_out(In_port_out), .C_out(C_out), .MDR_out(MDR_out),
        .MDR_enable(MDR_enable), .MAR_enable(MAR_enable), .Z_enable(Z_enable),
        .Y_enable(Y_enable), .PC_enable(PC_enable), .LO_enable(LO_enable),
        .HI_enable(HI_enable), .IR_enable(IR_enable), .CON_enable(CON_enable),
        .IncPC(IncPC), .Read(Read), .RAM_write_enable(RAM_write_enable),
        .out_port_enable(out_port_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .R_in(R_in), .R_out(R_out), .BA_out(BA_out), .opcode(opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t f0(input logic [31:0] i);
        return M_RUN | M_PCO | M_MARE | M_INC | vec_t'(i[31:27]);
    endfunction

    task automatic push_fetch(input logic [31:0] i);
        exp_q.push_back(f0(i));
        exp_q.push_back(M_RUN | M_RD | M_MDRE | vec_t'(i[31:27]));
        exp_q.push_back(M_RUN | M_MDRO | M_IRE | vec_t'(i[31:27]));
    endtask

    // Hold clr for one edge, then release so the next edge enters FETCH0
    task automatic start_instr(input logic [31:0] i, input logic c);
        clr = 1'b1; ir = i; con_ff = c; stop = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] i;
        i = 32'h1A920000;
        ir = i; con_ff = 1'b0; stop = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(V_IDLE);
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_hold: got %h expected %h", obs, exp_v); end
        clr = 1'b0;
        exp_q.push_back(f0(i));
        exp_q.push_back(M_RUN | M_RD | M_MDRE | vec_t'(i[31:27]));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL reset_release step %0d: got %h expected %h", k, obs, exp_v); end
        end
        #2 clr = 1'b1;
        #1;
        exp_q.push_back(V_IDLE);
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_async: got %h expected %h", obs, exp_v); end
        @(posedge clk); #1;
        exp_q.push_back(V_IDLE);
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_held: got %h expected %h", obs, exp_v); end
        clr = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(f0(i));
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_refetch: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_add();
        logic [31:0] i;
        vec_t op;
        int n;
        i = 32'h1A920000;
        op = vec_t'(i[31:27]);
        start_instr(i, 1'b0);
        push_fetch(i);
        exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YE | op);
        exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZE | op);
        exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN | op);
        exp_q.push_back(f0(i));
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL add step %0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_store();
        logic [31:0] i;
        vec_t op;
        int n;
        i = 32'h12000090;
        op = vec_t'(i[31:27]);
        start_instr(i, 1'b0);
        push_fetch(i);
        exp_q.push_back(M_RUN | M_GRB | M_BAO | M_YE | op);
        exp_q.push_back(M_RUN | M_CO | M_ZE | V_ADDOP);
        exp_q.push_back(M_RUN | M_ZLO | M_MARE | op);
        exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRE | op);
        exp_q.push_back(M_RUN | M_WR | op);
        exp_q.push_back(f0(i));
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL st step %0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] i;
        vec_t op;
        int n;
        i = 32'h9980000C;
        op = vec_t'(i[31:27]);
        for (int c = 0; c < 2; c++) begin
            start_instr(i, c[0]);
            push_fetch(i);
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONE | op);
            exp_q.push_back(M_RUN | M_PCO | M_YE | op);
            exp_q.push_back(M_RUN | M_CO | M_ZE | V_ADDOP);
            exp_q.push_back(M_RUN | M_ZLO | (c == 1 ? M_PCE : V_IDLE) | op);
            exp_q.push_back(f0(i));
            n = exp_q.size();
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                exp_v = exp_q.pop_front(); vectors++;
                if (obs !== exp_v) begin miscompares++; $display("FAIL br con_ff=%0d step %0d: got %h expected %h", c, k, obs, exp_v); end
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] i;
        vec_t op;
        int n;
        i = 32'h79880000;
        op = vec_t'(5'b01111);
        start_instr(i, 1'b0);
        push_fetch(i);
        exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YE | op);
        exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZE | op);
        exp_q.push_back(M_RUN | M_ZLO | M_LOE | op);
        exp_q.push_back(M_RUN | M_ZHO | M_HIE | op);
        exp_q.push_back(f0(i));
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL mul step %0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_nop();
        logic [31:0] i;
        int n;
        i = 32'hD0000000;
        start_instr(i, 1'b0);
        push_fetch(i);
        exp_q.push_back(f0(i));
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL nop step %0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_stop_ldi();
        logic [31:0] i;
        vec_t op;
        int n;
        i = 32'h08800075;
        op = vec_t'(i[31:27]);
        start_instr(i, 1'b0);
        push_fetch(i);
        exp_q.push_back(M_RUN | M_GRB | M_BAO | M_YE | op);
        exp_q.push_back(M_RUN | M_CO | M_ZE | V_ADDOP);
        exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN | op);
        for (int h = 0; h < 4; h++) exp_q.push_back(V_IDLE);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL ldi_stop step %0d: got %h expected %h", k, obs, exp_v); end
            if (k == 3) stop = 1'b1;
            if (k == 7) stop = 1'b0;
        end
        clr = 1'b1;
        #1;
        exp_q.push_back(V_IDLE);
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL ldi_stop_clr: got %h expected %h", obs, exp_v); end
        clr = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(f0(i));
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL ldi_stop_restart: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_halt_op();
        logic [31:0] i;
        int n;
        i = 32'hD8000000;
        start_instr(i, 1'b0);
        push_fetch(i);
        for (int h = 0; h < 3; h++) exp_q.push_back(V_IDLE);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); vectors++;
            if (obs !== exp_v) begin miscompares++; $display("FAIL halt step %0d: got %h expected %h", k, obs, exp_v); end
        end
        start_instr(32'h1A920000, 1'b0);
        @(posedge clk); #1;
        exp_q.push_back(f0(32'h1A920000));
        exp_v = exp_q.pop_front(); vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL halt_restart: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        clr = 1'b1; ir = '0; con_ff = 1'b0; stop = 1'b0;
        test_reset();
        test_add();
        test_store();
        test_branch();
        test_mul();
        test_nop();
        test_stop_ldi();
        test_halt_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
